fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that lets N_REQ producers share the single write port of one `fifo` instance (write/datain/full). It grants at most one producer per cycle and supports bounded bursts so a producer can stream consecutive words. It drives the FIFO write strobe and data combinationally, so a write is accepted on the same clock edge as the producer's ack. It sits between the producer blocks and the FIFO; the FIFO's read side is untouched.

## Interface
- N_REQ, 4, number of producers (2..16)
- DATA_W, 10, data width; must match the FIFO's DATA_W
- MAX_BURST, 4, max consecutive grants to one owner (>=1)
- clock  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- req  in  N_REQ  per-producer write request; held with data until ack
- req_data  in  N_REQ*DATA_W  producer i data at [i*DATA_W +: DATA_W]
- ack  out  N_REQ  one-hot or zero; ack[i]=1 means req_data slice i is written at this edge
- fifo_full  in  1  FIFO `full`
- fifo_write  out  1  FIFO `write`; equals |ack
- fifo_datain  out  DATA_W  FIFO `datain`; granted slice, 0 when no ack
- owner_id  out  $clog2(N_REQ)  current burst owner; 0 in IDLE
- busy  out  1  1 in OWN state

## Operation
- State: IDLE or OWN. Registers: rr_ptr (next priority index), owner, burst_cnt ($clog2(MAX_BURST+1) bits).
- Reset values: state=IDLE, rr_ptr=0, owner=0, burst_cnt=0. Combinational outputs with req=0 give ack=0, fifo_write=0, fifo_datain=0, owner_id=0, busy=0.
- fifo_full=1: ack=0 in every state. State, owner, burst_cnt, and rr_ptr hold. A stalled owner keeps ownership.
- IDLE, fifo_full=0, any req: winner = first set req index scanning rr_ptr, rr_ptr+1, ... mod N_REQ. ack[winner]=1.
  - If MAX_BURST==1: stay IDLE, rr_ptr<=winner+1 mod N_REQ.
  - Else: go to OWN, owner<=winner, burst_cnt<=1.
- OWN, req[owner]=1, fifo_full=0: ack[owner]=1, burst_cnt+1.
  - If the new count equals MAX_BURST: go to IDLE, rr_ptr<=owner+1 mod N_REQ, burst_cnt<=0.
- OWN, req[owner]=0: release with no bubble. In the same cycle, arbitrate exactly as in IDLE but with the scan start at owner+1 mod N_REQ. If no other req is set (or fifo_full=1): go to IDLE, rr_ptr<=owner+1, burst_cnt<=0.
- Other producers' requests are ignored while an owner holds its req.
- Data is never modified. fifo_datain = req_data slice of the acked index.
- A producer that deasserts req without an ack is legal; nothing is written.

## Timing
- Zero-cycle grant: ack, fifo_write, and fifo_datain are combinational from req, fifo_full, and registered state. The write lands at the same rising edge.
- No combinational path from ack back to req is permitted in producers.
- FIFO simultaneous read+write when full: the FIFO rejects the write, so fifo_full=1 alone blocks ack regardless of reads.
- Throughput: one word per cycle while fifo_full=0. No idle cycle between owners.
- Worst-case wait for a continuously requesting producer with FIFO space: (N_REQ-1)*MAX_BURST cycles.
- Reset asserted mid-burst: state returns to IDLE and rr_ptr to 0 immediately. ack drops combinationally. After reset deassertion, arbitration restarts from index 0.

## Structure
- Package `fifo_arb_pkg` holds:
  - state enum (ARB_IDLE, ARB_OWN)
  - ID width localparam derivation helper
  - rr_next(idx, N) wrap helper
- Sub-module `rr_pick`: a combinational rotating-priority picker. Inputs: req vector and start index. Outputs: valid and winner index. It is used once, with start = rr_ptr in IDLE or owner+1 on release.
- Top-level `fifo_wr_arbiter` holds the state register, burst counter, and output muxing. The `fifo` is instantiated by the parent, not inside this block.

## Test plan
- Single producer, N_REQ=4, MAX_BURST=4: req[2] held 6 cycles, fifo_full=0, data 0x0A..0x0F.
  - Required: ack[2] on all 6 cycles; busy drops after the 4th write for one IDLE-grant cycle, then burst restarts; FIFO contents 0x0A..0x0F in order.
- Fairness: req=4'b1111 held 16 cycles, MAX_BURST=2.
  - Required: grant order 0,0,1,1,2,2,3,3, repeated; each producer gets exactly 4 writes.
- Backpressure: owner 1 mid-burst (burst_cnt=1) sees fifo_full=1 for 3 cycles.
  - Required: ack=0 and owner_id=1 held; first cycle after full clears gives ack[1] with burst_cnt=2; no data lost or duplicated.
- Early release: owner 0 drops req after 1 write while req[3]=1.
  - Required: ack[3] in that same cycle; next rr start is 1.
- MAX_BURST=1, req=4'b0101 for 4 cycles.
  - Required: ack alternates 0,2,0,2; busy stays 0.
- Reset mid-burst on owner 2.
  - Required: ack=0 immediately, busy=0, owner_id=0; with req=4'b1111 after release, the first grant is index 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared types and index helpers for the FIFO write-port arbiter
package fifo_arb_pkg;
    typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer request/data bundle plus the FIFO write port
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 10
) ();
    localparam int ID_W = id_w(N_REQ);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic                    fifo_full;
    logic                    fifo_write;
    logic [DATA_W-1:0]       fifo_datain;
    logic [ID_W-1:0]         owner_id;
    logic                    busy;
    modport master (output req, req_data, fifo_full, input ack, fifo_write, fifo_datain, owner_id, busy);
    modport slave (input req, req_data, fifo_full, output ack, fifo_write, fifo_datain, owner_id, busy);
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker starting from a given index
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_start,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_winner
);
    logic [ID_W-1:0] w_idx;
    // Scan from the farthest offset back so the request nearest i_start wins last
    always_comb begin
        o_valid  = |i_req;
        o_winner = '0;
        w_idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = ID_W'((int'(i_start) + k) % N_REQ);
            if (i_req[w_idx]) o_winner = w_idx;
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-capable arbiter sharing one FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 10,
    parameter int MAX_BURST = 4
) (
    input  logic             clock,
    input  logic             reset,
    fifo_wr_arbiter_if.slave io_bus
);
    localparam int ID_W  = id_w(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t        r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_owner;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic              w_own;
    logic              w_own_hold;
    logic              w_pick_valid;
    logic              w_ack_en;
    logic              w_burst_end;
    logic [ID_W-1:0]   w_owner_next;
    logic [ID_W-1:0]   w_start;
    logic [ID_W-1:0]   w_pick;
    logic [ID_W-1:0]   w_grant;
    logic [N_REQ-1:0]  w_ack;
    logic [DATA_W-1:0] w_data;

    assign w_own        = r_state == ARB_OWN;
    assign w_own_hold   = w_own && io_bus.req[r_owner];
    assign w_owner_next = ID_W'(rr_next(int'(r_owner), N_REQ));
    assign w_start      = w_own ? w_owner_next : r_rr_ptr;
    assign w_grant      = w_own_hold ? r_owner : w_pick;
    assign w_ack_en     = !reset && !io_bus.fifo_full && (w_own_hold || w_pick_valid);
    assign w_burst_end  = (r_burst_cnt + CNT_W'(1)) == CNT_W'(MAX_BURST);

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .i_req    (io_bus.req),
        .i_start  (w_start),
        .o_valid  (w_pick_valid),
        .o_winner (w_pick)
    );

    // Track ownership and burst length; a released owner hands over in the same cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
        end else if (w_own_hold) begin
            if (!io_bus.fifo_full) begin
                if (w_burst_end) begin
                    r_state     <= ARB_IDLE;
                    r_rr_ptr    <= w_owner_next;
                    r_burst_cnt <= '0;
                end else begin
                    r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                end
            end
        end else if (!io_bus.fifo_full && w_pick_valid) begin
            if (MAX_BURST == 1) begin
                r_state  <= ARB_IDLE;
                r_rr_ptr <= ID_W'(rr_next(int'(w_pick), N_REQ));
            end else begin
                r_state     <= ARB_OWN;
                r_owner     <= w_pick;
                r_burst_cnt <= CNT_W'(1);
            end
        end else if (w_own) begin
            r_state     <= ARB_IDLE;
            r_rr_ptr    <= w_owner_next;
            r_burst_cnt <= '0;
        end
    end

    // Decode the grant into a one-hot ack and steer the granted data slice
    always_comb begin
        w_ack  = '0;
        w_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_ack_en && w_grant == ID_W'(i)) begin
                w_ack[i] = 1'b1;
                w_data   = io_bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign io_bus.ack         = w_ack;
    assign io_bus.fifo_write  = |w_ack;
    assign io_bus.fifo_datain = w_data;
    assign io_bus.owner_id    = w_own ? r_owner : '0;
    assign io_bus.busy        = w_own;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of burst, fairness, backpressure, release and reset
module tb_fifo_wr_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cnt2[4];
    logic [9:0] q4[$];

    always #5 clock = ~clock;

    fifo_wr_arbiter_if #(.N_REQ(4), .DATA_W(10)) b4 ();
    fifo_wr_arbiter_if #(.N_REQ(4), .DATA_W(10)) b2 ();
    fifo_wr_arbiter_if #(.N_REQ(4), .DATA_W(10)) b1 ();

    fifo_wr_arbiter #(.N_REQ(4), .DATA_W(10), .MAX_BURST(4)) u_b4 (.clock(clock), .reset(reset), .io_bus(b4));
    fifo_wr_arbiter #(.N_REQ(4), .DATA_W(10), .MAX_BURST(2)) u_b2 (.clock(clock), .reset(reset), .io_bus(b2));
    fifo_wr_arbiter #(.N_REQ(4), .DATA_W(10), .MAX_BURST(1)) u_b1 (.clock(clock), .reset(reset), .io_bus(b1));

    always @(posedge clock) if (b4.fifo_write) q4.push_back(b4.fifo_datain);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        b4.req = '0; b4.req_data = '0; b4.fifo_full = 1'b0;
        b2.req = '0; b2.req_data = '0; b2.fifo_full = 1'b0;
        b1.req = '0; b1.req_data = '0; b1.fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) cnt2[i] = 0;
        step(); step();
        #1;
        chk("rst_ack", 32'(b4.ack), 'h0);
        chk("rst_write", 32'(b4.fifo_write), 'h0);
        chk("rst_data", 32'(b4.fifo_datain), 'h0);
        chk("rst_owner", 32'(b4.owner_id), 'h0);
        chk("rst_busy", 32'(b4.busy), 'h0);
        step();
        reset = 1'b0;
        #1;
        chk("idle_ack", 32'(b4.ack), 'h0);
        // single producer, bursts of 4 with one IDLE-grant cycle between bursts
        for (int k = 0; k < 6; k++) begin
            step();
            b4.req = 4'b0100;
            b4.req_data[20 +: 10] = 10'(10'h0A + k);
            #1;
            chk("single_ack", 32'(b4.ack), 'h4);
            chk("single_data", 32'(b4.fifo_datain), 32'(10'h0A + k));
            chk("single_busy", 32'(b4.busy), (k == 0 || k == 4) ? 'h0 : 'h1);
        end
        step();
        b4.req = 4'b0000;
        step();
        #1;
        chk("q_size1", 32'(q4.size()), 'd6);
        for (int k = 0; k < 6; k++) chk("q_single", 32'(q4[k]), 32'(10'h0A + k));
        // backpressure: owner 1 mid-burst stalls for three cycles
        b4.req = 4'b0010;
        b4.req_data[10 +: 10] = 10'h21;
        #1;
        chk("bp_grant", 32'(b4.ack), 'h2);
        for (int k = 0; k < 3; k++) begin
            step();
            b4.fifo_full = 1'b1;
            b4.req_data[10 +: 10] = 10'h22;
            #1;
            chk("bp_stall_ack", 32'(b4.ack), 'h0);
            chk("bp_stall_wr", 32'(b4.fifo_write), 'h0);
            chk("bp_owner", 32'(b4.owner_id), 'h1);
            chk("bp_busy", 32'(b4.busy), 'h1);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            b4.fifo_full = 1'b0;
            b4.req_data[10 +: 10] = 10'(10'h22 + k);
            #1;
            chk("bp_resume_ack", 32'(b4.ack), 'h2);
            chk("bp_resume_data", 32'(b4.fifo_datain), 32'(10'h22 + k));
            chk("bp_resume_busy", 32'(b4.busy), 'h1);
        end
        // early release: owner 0 drops after one write, producer 3 takes over at once
        step();
        b4.req = 4'b0001;
        b4.req_data[0 +: 10] = 10'h31;
        #1;
        chk("bp_burst_done", 32'(b4.busy), 'h0);
        chk("q_size2", 32'(q4.size()), 'd10);
        for (int k = 0; k < 4; k++) chk("q_bp", 32'(q4[6 + k]), 32'(10'h21 + k));
        chk("er_grant0", 32'(b4.ack), 'h1);
        step();
        b4.req = 4'b1000;
        b4.req_data[30 +: 10] = 10'h3C;
        #1;
        chk("er_ack3", 32'(b4.ack), 'h8);
        chk("er_data3", 32'(b4.fifo_datain), 'h3C);
        chk("er_owner_old", 32'(b4.owner_id), 'h0);
        step();
        #1;
        chk("er_owner_new", 32'(b4.owner_id), 'h3);
        chk("er_hold3", 32'(b4.ack), 'h8);
        step();
        b4.req = 4'b0000;
        // reset mid-burst on owner 2
        step();
        b4.req = 4'b0100;
        #1;
        chk("rb_grant2", 32'(b4.ack), 'h4);
        step();
        #1;
        chk("rb_owner2", 32'(b4.owner_id), 'h2);
        reset = 1'b1;
        #1;
        chk("rb_ack", 32'(b4.ack), 'h0);
        chk("rb_busy", 32'(b4.busy), 'h0);
        chk("rb_owner", 32'(b4.owner_id), 'h0);
        step();
        reset = 1'b0;
        b4.req = 4'b1111;
        #1;
        chk("rb_restart", 32'(b4.ack), 'h1);
        step();
        b4.req = 4'b0000;
        // fairness with MAX_BURST=2
        for (int i = 0; i < 4; i++) b2.req_data[i*10 +: 10] = 10'(10'h30 + i);
        for (int k = 0; k < 16; k++) begin
            step();
            b2.req = 4'b1111;
            #1;
            chk("fair_ack", 32'(b2.ack), 32'(1 << ((k / 2) % 4)));
            chk("fair_data", 32'(b2.fifo_datain), 32'(10'h30 + (k / 2) % 4));
            for (int i = 0; i < 4; i++) if (b2.ack[i]) cnt2[i]++;
        end
        step();
        b2.req = 4'b0000;
        for (int i = 0; i < 4; i++) chk("fair_count", 32'(cnt2[i]), 'd4);
        // single-word grants alternate between the two requesters
        for (int k = 0; k < 4; k++) begin
            step();
            b1.req = 4'b0101;
            #1;
            chk("mb1_ack", 32'(b1.ack), (k % 2 == 0) ? 'h1 : 'h4);
            chk("mb1_busy", 32'(b1.busy), 'h0);
        end
        step();
        b1.req = 4'b0000;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
